// File: rtl/movegen_emitter_if.sv
// Move stream between the emitter and the downstream legality filter / move list.
// Each beat carries one (from,to) square pair under valid/ready flow control.
interface movegen_emitter_if;
    logic       m_valid;
    logic       m_ready;
    logic [5:0] m_from;
    logic [5:0] m_to;

    modport master (output m_valid, output m_from, output m_to, input m_ready);
    modport slave  (input m_valid, input m_from, input m_to, output m_ready);
endinterface

// File: rtl/movegen_emitter.sv
// Sequencer around the 8x8 move-generator array: loads attackers, strobes each
// side-to-play source square in turn and serialises its target set as (from,to) moves.
module movegen_emitter #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [63:0]          i_play_mask,
    input  logic [63:0]          i_targets,
    output logic                 o_load_attackers,
    output logic [63:0]          o_emit_move,
    movegen_emitter_if.master    m,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_W-1:0]     o_move_count
);

    typedef enum logic [2:0] {IDLE, ATTACK, EMIT, DRAIN, DONE} state_e;

    state_e             state_q;
    logic [63:0]        pend_q;
    logic [63:0]        tgt_q;
    logic               load_q;
    logic [63:0]        emit_q;
    logic               valid_q;
    logic [5:0]         from_q;
    logic [5:0]         to_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;

    function automatic logic [5:0] lsb64(input logic [63:0] v);
        lsb64 = '0;
        for (int i = 63; i >= 0; i--)
            if (v[i]) lsb64 = 6'(i);
    endfunction

    // Combinational helpers: lowest pending source and the target set after the current handshake.
    logic [5:0]  pend_src;
    logic [63:0] pend_oh;
    logic [63:0] tgt_clr_d;
    logic [5:0]  tgt_clr_lsb;
    logic [5:0]  tgt_in_lsb;

    assign pend_src    = lsb64(pend_q);
    assign pend_oh     = 64'(1) << pend_src;
    assign tgt_clr_d   = tgt_q & ~(64'(1) << to_q);
    assign tgt_clr_lsb = lsb64(tgt_clr_d);
    assign tgt_in_lsb  = lsb64(i_targets);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            tgt_q   <= '0;
            load_q  <= 1'b0;
            emit_q  <= '0;
            valid_q <= 1'b0;
            from_q  <= '0;
            to_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            load_q <= 1'b0;
            emit_q <= '0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= ATTACK;
                    load_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                    pend_q  <= i_play_mask;
                end
                ATTACK: if (pend_q == '0) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= EMIT;
                    emit_q  <= pend_oh;
                end
                EMIT: begin
                    // emit_q is the strobe for pend_src this cycle; the array answers on i_targets.
                    from_q  <= pend_src;
                    pend_q  <= pend_q & ~pend_oh;
                    tgt_q   <= i_targets;
                    valid_q <= (i_targets != '0);
                    to_q    <= tgt_in_lsb;
                    state_q <= DRAIN;
                end
                DRAIN: if (tgt_q == '0) begin
                    if (pend_q != '0) begin
                        state_q <= EMIT;
                        emit_q  <= pend_oh;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end else if (valid_q && m.m_ready) begin
                    tgt_q   <= tgt_clr_d;
                    valid_q <= (tgt_clr_d != '0);
                    to_q    <= tgt_clr_lsb;
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_load_attackers = load_q;
    assign o_emit_move      = emit_q;
    assign m.m_valid        = valid_q;
    assign m.m_from         = from_q;
    assign m.m_to           = to_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_move_count     = cnt_q;

endmodule

// File: tb/tb_movegen_emitter.sv
// Scoreboard bench for movegen_emitter: models the cell array's target response,
// predicts move order, emit strobes, latency and the saturating move count.
module tb_movegen_emitter;
    localparam int CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [63:0]       play;
    logic [63:0]       tgts;
    logic              load;
    logic [63:0]       emit;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  cnt;

    movegen_emitter_if bus();

    movegen_emitter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .i_play_mask(play), .i_targets(tgts),
        .o_load_attackers(load), .o_emit_move(emit), .m(bus),
        .o_busy(busy), .o_done(done), .o_move_count(cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Cell-array model: each source square answers with its entry when strobed.
    logic [63:0] tgt_tab [64];
    always_comb begin
        tgts = '0;
        for (int i = 0; i < 64; i++)
            if (emit[i]) tgts = tgt_tab[i];
    end

    logic [11:0] sbq [$];
    logic [63:0] emq [$];
    int cyc = 0;
    int st_cyc, load_cyc, done_cyc, vfirst_cyc, done_n;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (load) begin
                load_cyc = cyc;
                chk("load_emit_excl", emit, 64'h0);
            end
            if (done) begin
                done_cyc = cyc;
                done_n++;
            end
            if (bus.m_valid && vfirst_cyc < 0) vfirst_cyc = cyc;
            if (emit != '0) begin
                if (emq.size() == 0) chk("emit_extra", emit, 64'h0);
                else chk("emit_order", emit, emq.pop_front());
            end
            if (bus.m_valid && bus.m_ready) begin
                if (sbq.size() == 0) chk("move_extra", 64'({bus.m_from, bus.m_to}), 64'hFFFF);
                else chk("move", 64'({bus.m_from, bus.m_to}), 64'(sbq.pop_front()));
            end
        end
    end

    task automatic predict(input logic [63:0] mask, output int total);
        total = 0;
        for (int f = 0; f < 64; f++) if (mask[f]) begin
            emq.push_back(64'(1) << f);
            for (int t = 0; t < 64; t++) if (tgt_tab[f][t]) begin
                sbq.push_back({6'(f), 6'(t)});
                total++;
            end
        end
    endtask

    task automatic kick(input logic [63:0] mask, input logic rdy);
        @(negedge clk);
        load_cyc = -1; done_cyc = -1; vfirst_cyc = -1; done_n = 0;
        play = mask;
        bus.m_ready = rdy;
        start = 1'b1;
        st_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.m_valid && n < 100) begin @(negedge clk); n++; end
        chk("valid_timeout", 64'(bus.m_valid), 64'h1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_n == 0 && n < 5000) begin @(negedge clk); n++; end
        chk("done_timeout", 64'(done_n), 64'h1);
        @(negedge clk);
        @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'h0);
        chk("emq_empty", 64'(emq.size()), 64'h0);
        chk("done_once", 64'(done_n), 64'h1);
        chk("idle_busy", 64'(busy), 64'h0);
    endtask

    int total;

    initial begin
        rst = 1'b1; start = 1'b0; play = '0; bus.m_ready = 1'b1;
        for (int i = 0; i < 64; i++) tgt_tab[i] = '0;
        load_cyc = -1; done_cyc = -1; vfirst_cyc = -1; done_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_load", 64'(load), 64'h0);
        chk("rst_emit", emit, 64'h0);
        chk("rst_valid", 64'(bus.m_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_from_to", 64'({bus.m_from, bus.m_to}), 64'h0);
        chk("rst_cnt", 64'(cnt), 64'h0);
        rst = 1'b0;

        // Empty side to play
        predict(64'h0, total);
        kick(64'h0, 1'b1);
        wait_done();
        chk("empty_load_cyc", 64'(load_cyc - st_cyc), 64'd1);
        chk("empty_done_cyc", 64'(done_cyc - st_cyc), 64'd2);
        chk("empty_no_valid", 64'(vfirst_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("empty_cnt", 64'(cnt), 64'h0);

        // Single piece on b1, two targets, ready high
        tgt_tab[1] = (64'h1 << 16) | (64'h1 << 18);
        predict(64'h2, total);
        kick(64'h2, 1'b1);
        wait_done();
        chk("b1_first_valid", 64'(vfirst_cyc - st_cyc), 64'd3);
        chk("b1_done_cyc", 64'(done_cyc - st_cyc), 64'd6);
        chk("b1_cnt", 64'(cnt), 64'(total));

        // Same with backpressure: beat must hold for 5 cycles
        predict(64'h2, total);
        kick(64'h2, 1'b0);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 64'(bus.m_valid), 64'h1);
            chk("stall_beat", 64'({bus.m_from, bus.m_to}), 64'({6'd1, 6'd16}));
            @(negedge clk);
        end
        bus.m_ready = 1'b1;
        wait_done();
        chk("stall_cnt", 64'(cnt), 64'd2);

        // Three sources, one with no targets
        tgt_tab[6] = 64'h1 << 21;
        tgt_tab[1] = 64'h1 << 16;
        predict((64'h1 << 1) | (64'h1 << 6) | (64'h1 << 12), total);
        kick((64'h1 << 1) | (64'h1 << 6) | (64'h1 << 12), 1'b1);
        wait_done();
        chk("three_cnt", 64'(cnt), 64'd2);

        // Reset mid-DRAIN after one accepted move; a start while busy is ignored
        tgt_tab[1] = (64'h1 << 16) | (64'h1 << 18);
        predict(64'h2, total);
        kick(64'h2, 1'b0);
        wait_valid();
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        start = 1'b1;
        play = 64'hFF00;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ign", 64'({bus.m_valid, bus.m_from, bus.m_to}), 64'({1'b1, 6'd1, 6'd18}));
        chk("busy_start_cnt", 64'(cnt), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 64'(bus.m_valid), 64'h0);
        chk("midrst_emit", emit, 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_cnt", 64'(cnt), 64'h0);
        rst = 1'b0;
        sbq.delete();
        emq.delete();
        bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("postrst_idle", 64'({busy, bus.m_valid}), 64'h0);

        // Full board, 4 targets each: 256 moves, count saturates
        for (int i = 0; i < 64; i++) tgt_tab[i] = 64'hF << (i % 60);
        predict('1, total);
        kick('1, 1'b1);
        wait_done();
        chk("sat_total", 64'(total), 64'd256);
        chk("sat_cnt", 64'(cnt), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
